run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer_pkg.sv | 15 +
 rtl/cycle_stats.sv | 56 +++++
 rtl/run_sequencer.sv | 149 ++++++++++++++
 tb/tb_run_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_sequencer_pkg.sv
// Shared types and default sizing for the run sequencer and its statistics block.
package run_sequencer_pkg;

  localparam int unsigned DefaultCntWidth      = 32;
  localparam int unsigned DefaultTimeoutCycles = 1048576;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StLaunch,
    StRun,
    StFinish
  } seq_state_e;

endpackage

// File: rtl/cycle_stats.sv
// Per-run latency statistics: last, min, max, saturating total and completed-run count.
module cycle_stats #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 clear,
  input  logic                 complete,
  input  logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] runs_done,
  output logic [CNT_WIDTH-1:0] cycles_last,
  output logic [CNT_WIDTH-1:0] cycles_min,
  output logic [CNT_WIDTH-1:0] cycles_max,
  output logic [CNT_WIDTH-1:0] cycles_total
);

  localparam logic [CNT_WIDTH-1:0] AllOnes = '1;

  logic [CNT_WIDTH-1:0] runs_q, last_q, min_q, max_q, total_q;
  logic [CNT_WIDTH:0]   total_sum;

  // One extra bit exposes the carry used for saturation.
  assign total_sum = {1'b0, total_q} + {1'b0, count};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      runs_q  <= '0;
      last_q  <= '0;
      min_q   <= AllOnes;
      max_q   <= '0;
      total_q <= '0;
    end else if (clear) begin
      runs_q  <= '0;
      min_q   <= AllOnes;
      max_q   <= '0;
      total_q <= '0;
    end else if (complete) begin
      runs_q <= runs_q + 1'b1;
      last_q <= count;
      if (count < min_q) begin
        min_q <= count;
      end
      if (count > max_q) begin
        max_q <= count;
      end
      total_q <= total_sum[CNT_WIDTH] ? AllOnes : total_sum[CNT_WIDTH-1:0];
    end
  end

  assign runs_done    = runs_q;
  assign cycles_last  = last_q;
  assign cycles_min   = min_q;
  assign cycles_max   = max_q;
  assign cycles_total = total_q;

endmodule

// File: rtl/run_sequencer.sv
// Launches an accelerator a requested number of times over its enable/ready handshake,
// aborting any run that exceeds TIMEOUT_CYCLES and collecting per-run latency statistics.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = DefaultCntWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] iterations,
  output logic                 accel_enable,
  input  logic                 accel_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] runs_done,
  output logic [CNT_WIDTH-1:0] cycles_last,
  output logic [CNT_WIDTH-1:0] cycles_min,
  output logic [CNT_WIDTH-1:0] cycles_max,
  output logic [CNT_WIDTH-1:0] cycles_total
);

  // The latency counter must reach TIMEOUT_CYCLES-1 without wrapping.
  if (CNT_WIDTH < 64) begin : gen_timeout_check
    if ((TIMEOUT_CYCLES < 2) ||
        (64'(TIMEOUT_CYCLES) > ((64'd1 << CNT_WIDTH) - 64'd1))) begin : gen_timeout_bad
      $error("run_sequencer: TIMEOUT_CYCLES must be in [2, 2**CNT_WIDTH-1]");
    end
  end

  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  seq_state_e           state_q;
  logic [CNT_WIDTH-1:0] iter_q;
  logic [CNT_WIDTH-1:0] lat_q;
  logic                 enable_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;

  logic [CNT_WIDTH-1:0] lat_inc;
  logic [CNT_WIDTH-1:0] runs_next;
  logic                 timed_out;
  logic                 stats_clear;
  logic                 run_complete;

  assign lat_inc      = lat_q + 1'b1;
  assign runs_next    = runs_done + 1'b1;
  assign timed_out    = (state_q inside {StLaunch, StRun}) && (lat_q == TimeoutLast);
  assign stats_clear  = (state_q == StIdle) && start;
  // The timeout wins over a completion seen in the same cycle.
  assign run_complete = (state_q == StRun) && accel_ready && !timed_out;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= StIdle;
      iter_q   <= '0;
      lat_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            iter_q  <= iterations;
            if (iterations == '0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StArm;
            end
          end
        end
        StArm: begin
          if (accel_ready) begin
            state_q  <= StLaunch;
            enable_q <= 1'b1;
            lat_q    <= '0;
          end
        end
        StLaunch: begin
          if (timed_out) begin
            state_q  <= StFinish;
            enable_q <= 1'b0;
            error_q  <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            lat_q <= lat_inc;
            if (!accel_ready) begin
              state_q  <= StRun;
              enable_q <= 1'b0;
            end
          end
        end
        StRun: begin
          if (timed_out) begin
            state_q  <= StFinish;
            enable_q <= 1'b0;
            error_q  <= 1'b1;
            done_q   <= 1'b1;
          end else if (accel_ready) begin
            if (runs_next == iter_q) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StArm;
            end
          end else begin
            lat_q <= lat_inc;
          end
        end
        StFinish: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The completion cycle itself is part of the reported latency.
  cycle_stats #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cycle_stats (
    .aclk         (aclk),
    .areset       (areset),
    .clear        (stats_clear),
    .complete     (run_complete),
    .count        (lat_inc),
    .runs_done    (runs_done),
    .cycles_last  (cycles_last),
    .cycles_min   (cycles_min),
    .cycles_max   (cycles_max),
    .cycles_total (cycles_total)
  );

  assign accel_enable = enable_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Drives run_sequencer against a behavioural accelerator and checks batch results
// against statistics computed directly from the chosen per-run handshake delays.
module tb_run_sequencer;

  localparam int unsigned W  = 6;
  localparam int unsigned TO = 16;
  localparam logic [63:0] AllOnes = (64'd1 << W) - 64'd1;

  logic         aclk;
  logic         areset;
  logic         start;
  logic [W-1:0] iterations;
  logic         accel_enable;
  logic         accel_ready;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] runs_done;
  logic [W-1:0] cycles_last;
  logic [W-1:0] cycles_min;
  logic [W-1:0] cycles_max;
  logic [W-1:0] cycles_total;

  int n_tests = 0;
  int n_fail  = 0;

  run_sequencer #(
    .CNT_WIDTH      (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .start        (start),
    .iterations   (iterations),
    .accel_enable (accel_enable),
    .accel_ready  (accel_ready),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .runs_done    (runs_done),
    .cycles_last  (cycles_last),
    .cycles_min   (cycles_min),
    .cycles_max   (cycles_max),
    .cycles_total (cycles_total)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Accelerator model: D edges after it first sees enable it drops ready, and H edges
  // later raises it again; the sequencer then measures a latency of D+H+1 cycles.
  int acc_d    [256];
  int acc_h    [256];
  bit acc_hang [256];
  int acc_total = 0;
  bit acc_active;
  int acc_t, cur_d, cur_h;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      accel_ready <= 1'b1;
      acc_active  <= 1'b0;
      acc_t       <= 0;
    end else if (!acc_active) begin
      if (accel_enable && !acc_hang[acc_total & 255]) begin
        acc_active <= 1'b1;
        acc_t      <= 2;
        cur_d      <= acc_d[acc_total & 255];
        cur_h      <= acc_h[acc_total & 255];
        acc_total  <= acc_total + 1;
        if (acc_d[acc_total & 255] == 1) accel_ready <= 1'b0;
      end
    end else begin
      if (acc_t == cur_d) accel_ready <= 1'b0;
      if (acc_t == cur_d + cur_h) begin
        accel_ready <= 1'b1;
        acc_active  <= 1'b0;
      end
      acc_t <= acc_t + 1;
    end
  end

  int          plan_d [16];
  int          plan_h [16];
  logic [63:0] exp_last = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_batch(input int iters, input int hang_run, input bit noise,
                           input string name);
    int          base, n_ok, lat, cyc, streak, last_streak, en_seen;
    logic [63:0] e_min, e_max, e_tot;
    base = acc_total;
    for (int i = 0; i < iters; i++) begin
      acc_d[(base + i) & 255]    = plan_d[i];
      acc_h[(base + i) & 255]    = plan_h[i];
      acc_hang[(base + i) & 255] = (i == hang_run);
    end
    n_ok  = (hang_run >= 0 && hang_run < iters) ? hang_run : iters;
    e_min = AllOnes;
    e_max = 0;
    e_tot = 0;
    for (int i = 0; i < n_ok; i++) begin
      lat = plan_d[i] + plan_h[i] + 1;
      if (64'(lat) < e_min) e_min = 64'(lat);
      if (64'(lat) > e_max) e_max = 64'(lat);
      e_tot    = (e_tot + 64'(lat) > AllOnes) ? AllOnes : e_tot + 64'(lat);
      exp_last = 64'(lat);
    end

    @(negedge aclk);
    start      = 1'b1;
    iterations = W'(iters);
    @(negedge aclk);
    start      = 1'b0;
    iterations = W'($urandom_range(0, 63));
    check({name, "_busy_on"}, 64'(busy), 1);

    cyc = 0; streak = 0; last_streak = 0; en_seen = 0;
    while (!done && cyc < 400) begin
      if (accel_enable) begin
        streak++;
        en_seen++;
      end else if (streak != 0) begin
        last_streak = streak;
        streak      = 0;
      end
      start = noise && (cyc % 5 == 2);
      if (start) iterations = W'($urandom_range(1, 20));
      @(negedge aclk);
      cyc++;
    end
    start = 1'b0;
    if (streak != 0) last_streak = streak;

    check({name, "_done_seen"},   64'(done),         1);
    check({name, "_busy_done"},   64'(busy),         1);
    check({name, "_enable_off"},  64'(accel_enable), 0);
    check({name, "_error"},       64'(error),        64'(n_ok != iters));
    check({name, "_runs_done"},   64'(runs_done),    64'(n_ok));
    check({name, "_cycles_last"}, 64'(cycles_last),  exp_last);
    check({name, "_cycles_min"},  64'(cycles_min),   e_min);
    check({name, "_cycles_max"},  64'(cycles_max),   e_max);
    check({name, "_cycles_tot"},  64'(cycles_total), e_tot);
    if (iters == 0) begin
      check({name, "_no_enable"}, 64'(en_seen), 0);
      // Downstream logic samples done on the second rising edge after start is driven.
      check({name, "_done_edge"}, 64'(cyc + 2), 2);
    end
    if (n_ok != iters) check({name, "_timeout_len"}, 64'(last_streak), 64'(TO));

    // A start during the done cycle must be ignored.
    if (noise) begin
      start      = 1'b1;
      iterations = W'(7);
    end
    @(negedge aclk);
    start = 1'b0;
    check({name, "_done_1cyc"}, 64'(done), 0);
    check({name, "_busy_off"},  64'(busy), 0);
    @(negedge aclk);
    check({name, "_stay_idle"}, 64'(busy), 0);
    check({name, "_runs_kept"}, 64'(runs_done), 64'(n_ok));
  endtask

  task automatic reset_checks(input string name);
    check({name, "_enable"}, 64'(accel_enable), 0);
    check({name, "_busy"},   64'(busy),         0);
    check({name, "_done"},   64'(done),         0);
    check({name, "_error"},  64'(error),        0);
    check({name, "_runs"},   64'(runs_done),    0);
    check({name, "_last"},   64'(cycles_last),  0);
    check({name, "_min"},    64'(cycles_min),   AllOnes);
    check({name, "_max"},    64'(cycles_max),   0);
    check({name, "_total"},  64'(cycles_total), 0);
  endtask

  initial begin
    int iters, hang_run, cyc;
    start      = 1'b0;
    iterations = '0;
    areset     = 1'b0;
    #2 areset  = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    reset_checks("por");
    areset = 1'b0;
    @(negedge aclk);

    // Three runs of latency 7.
    for (int i = 0; i < 3; i++) begin plan_d[i] = 1; plan_h[i] = 5; end
    run_batch(3, -1, 1'b1, "lat7x3");

    // Latencies 4 then 10.
    plan_d[0] = 1; plan_h[0] = 2;
    plan_d[1] = 1; plan_h[1] = 8;
    run_batch(2, -1, 1'b0, "lat4_10");

    run_batch(0, -1, 1'b1, "zero_iter");

    // Ready never drops: the only run aborts.
    plan_d[0] = 1; plan_h[0] = 1;
    run_batch(1, 0, 1'b0, "hang_first");

    // Second run hangs after a good first run.
    plan_d[0] = 2; plan_h[0] = 3;
    plan_d[1] = 1; plan_h[1] = 1;
    run_batch(3, 1, 1'b1, "hang_second");

    // Six runs of latency 12 overflow a 6-bit total.
    for (int i = 0; i < 6; i++) begin plan_d[i] = 2; plan_h[i] = 9; end
    run_batch(6, -1, 1'b0, "saturate");

    for (int b = 0; b < 8; b++) begin
      iters = $urandom_range(1, 4);
      for (int i = 0; i < iters; i++) begin
        plan_d[i] = $urandom_range(1, 3);
        plan_h[i] = $urandom_range(1, 8);
      end
      hang_run = ($urandom_range(0, 3) == 0) ? $urandom_range(0, iters - 1) : -1;
      run_batch(iters, hang_run, 1'($urandom_range(0, 1)), $sformatf("rand%0d", b));
    end

    // Reset while run 2 of 4 is in progress.
    for (int i = 0; i < 4; i++) begin plan_d[i] = 1; plan_h[i] = 3; end
    for (int i = 0; i < 4; i++) begin
      acc_d[(acc_total + i) & 255]    = plan_d[i];
      acc_h[(acc_total + i) & 255]    = plan_h[i];
      acc_hang[(acc_total + i) & 255] = 1'b0;
    end
    @(negedge aclk);
    start      = 1'b1;
    iterations = W'(4);
    @(negedge aclk);
    start = 1'b0;
    cyc   = 0;
    while (!(runs_done == W'(1) && !accel_enable && !accel_ready) && cyc < 200) begin
      @(negedge aclk);
      cyc++;
    end
    check("rst_run_reached", 64'(cyc < 200), 1);
    #2 areset = 1'b1;
    #1 reset_checks("rst_run");
    exp_last = 0;
    @(negedge aclk);
    areset = 1'b0;

    // Reset while enable is high must drop it without waiting for a clock.
    plan_d[0] = 3; plan_h[0] = 2;
    acc_d[acc_total & 255]    = 3;
    acc_h[acc_total & 255]    = 2;
    acc_hang[acc_total & 255] = 1'b0;
    @(negedge aclk);
    start      = 1'b1;
    iterations = W'(2);
    @(negedge aclk);
    start = 1'b0;
    cyc   = 0;
    while (!accel_enable && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    check("rst_launch_reached", 64'(accel_enable), 1);
    #2 areset = 1'b1;
    #1 check("rst_launch_enable", 64'(accel_enable), 0);
    check("rst_launch_busy", 64'(busy), 0);
    @(negedge aclk);
    areset = 1'b0;

    // Normal operation resumes after reset.
    plan_d[0] = 1; plan_h[0] = 1;
    plan_d[1] = 3; plan_h[1] = 4;
    run_batch(2, -1, 1'b1, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
